// File: rtl/booth_divider_pkg.sv
// Shared arithmetic-unit definitions for the divider: FSM state codes, default width,
// and the quotient fill value returned on divide-by-zero.
package booth_divider_pkg;

  localparam int ARITH_WIDTH = 8;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_ITER = 2'd1;
  localparam state_t ST_FIX  = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  // Every quotient bit is set on divide-by-zero, whatever the width.
  localparam logic DBZ_QUOTIENT_FILL = 1'b1;

endpackage

// File: rtl/booth_divider_if.sv
// Start/done handshake and operand/result bus shared by the divider and its controller.
interface booth_divider_if import booth_divider_pkg::*; #(
  parameter int W = ARITH_WIDTH
) ();

  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic         dbz;
  logic [W-1:0] QR;
  logic [W-1:0] AC;

  modport master (output start, dividend, divisor,
                  input  busy, done, dbz, QR, AC);

  modport slave  (input  start, dividend, divisor,
                  output busy, done, dbz, QR, AC);

endinterface

// File: rtl/booth_divider_step.sv
// One non-restoring iteration: shift {A,Q} left, then subtract or add M by the old sign of A.
module divider_step import booth_divider_pkg::*; #(
  parameter int W = ARITH_WIDTH
) (
  input  logic [W:0]   a_i,
  input  logic         q_msb_i,
  input  logic [W-1:0] m_i,
  output logic [W:0]   a_o,
  output logic         q_bit_o
);

  logic [W:0] a_sh;

  always_comb begin
    a_sh = {a_i[W-1:0], q_msb_i};
    if (!a_i[W]) begin
      a_o = a_sh - {1'b0, m_i};
    end else begin
      a_o = a_sh + {1'b0, m_i};
    end
    q_bit_o = ~a_o[W];
  end

endmodule

// File: rtl/booth_divider.sv
// Sequential non-restoring divider: quotient in QR, remainder in AC, one step per clock.
// Define DIVIDER_SIGNED_EN for two's-complement operands (truncation toward zero).
module booth_divider import booth_divider_pkg::*; #(
  parameter int DIVIDEND_WIDTH = ARITH_WIDTH,
  parameter int DIVISOR_WIDTH  = ARITH_WIDTH
) (
  input logic             clk,
  input logic             rst,
  booth_divider_if.slave  bus
);

  // Both widths are required to match; the smaller is taken so a mismatch cannot overrun.
  localparam int W  = (DIVIDEND_WIDTH < DIVISOR_WIDTH) ? DIVIDEND_WIDTH : DIVISOR_WIDTH;
  localparam int CW = $clog2(W + 1);

  state_t        state_q, state_d;
  logic [W:0]    a_q, a_d;
  logic [W-1:0]  q_q, q_d;
  logic [W-1:0]  m_q, m_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  qr_q, qr_d;
  logic [W-1:0]  ac_q, ac_d;
  logic          dbz_q, dbz_d;
  logic [W:0]    a_step;
  logic          q_bit;
  logic [W-1:0]  rem_fix;
  logic [W-1:0]  dvd_mag, dvs_mag;

  divider_step #(.W(W)) u_step (
    .a_i     (a_q),
    .q_msb_i (q_q[W-1]),
    .m_i     (m_q),
    .a_o     (a_step),
    .q_bit_o (q_bit)
  );

`ifdef DIVIDER_SIGNED_EN
  logic negq_q, negq_d;
  logic negr_q, negr_d;

  assign dvd_mag = bus.dividend[W-1] ? (~bus.dividend + 1'b1) : bus.dividend;
  assign dvs_mag = bus.divisor[W-1]  ? (~bus.divisor  + 1'b1) : bus.divisor;

  always_ff @(posedge clk) begin
    if (rst) begin
      negq_q <= 1'b0;
      negr_q <= 1'b0;
    end else begin
      negq_q <= negq_d;
      negr_q <= negr_d;
    end
  end
`else
  assign dvd_mag = bus.dividend;
  assign dvs_mag = bus.divisor;
`endif

  // The true remainder always fits in W bits, so the final correction can drop the sign bit.
  assign rem_fix = a_q[W] ? (a_q[W-1:0] + m_q) : a_q[W-1:0];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    count_d = count_q;
    qr_d    = qr_q;
    ac_d    = ac_q;
    dbz_d   = dbz_q;
`ifdef DIVIDER_SIGNED_EN
    negq_d  = negq_q;
    negr_d  = negr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.divisor == '0) begin
            qr_d    = {W{DBZ_QUOTIENT_FILL}};
            ac_d    = bus.dividend;
            dbz_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            a_d     = '0;
            q_d     = dvd_mag;
            m_d     = dvs_mag;
            count_d = CW'(W);
            dbz_d   = 1'b0;
`ifdef DIVIDER_SIGNED_EN
            negq_d  = bus.dividend[W-1] ^ bus.divisor[W-1];
            negr_d  = bus.dividend[W-1];
`endif
            state_d = ST_ITER;
          end
        end
      end
      ST_ITER: begin
        a_d     = a_step;
        q_d     = {q_q[W-2:0], q_bit};
        count_d = count_q - 1'b1;
        if (count_q == CW'(1)) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
`ifdef DIVIDER_SIGNED_EN
        qr_d = negq_q ? (~q_q + 1'b1) : q_q;
        ac_d = negr_q ? (~rem_fix + 1'b1) : rem_fix;
`else
        qr_d = q_q;
        ac_d = rem_fix;
`endif
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      count_q <= '0;
      qr_q    <= '0;
      ac_q    <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      count_q <= count_d;
      qr_q    <= qr_d;
      ac_q    <= ac_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.busy = (state_q == ST_ITER) || (state_q == ST_FIX);
  assign bus.done = (state_q == ST_DONE);
  assign bus.dbz  = dbz_q;
  assign bus.QR   = qr_q;
  assign bus.AC   = ac_q;

endmodule

// File: tb/tb_booth_divider.sv
// Self-checking bench for booth_divider: directed cases plus random operands against an
// arithmetic reference model (signed model when DIVIDER_SIGNED_EN is defined).
module tb_booth_divider;

  localparam int W = 8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  booth_divider_if #(.W(W)) bus ();

  booth_divider #(.DIVIDEND_WIDTH(W), .DIVISOR_WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference: plain division, truncating toward zero in signed mode.
  task automatic refModel(input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                          output logic [W-1:0] expQ, output logic [W-1:0] expR,
                          output logic expDbz);
    int a;
    int b;
    if (dvs == 0) begin
      expQ   = 8'hFF;
      expR   = dvd;
      expDbz = 1'b1;
    end else begin
`ifdef DIVIDER_SIGNED_EN
      a = int'($signed(dvd));
      b = int'($signed(dvs));
`else
      a = int'(dvd);
      b = int'(dvs);
`endif
      expQ   = W'(a / b);
      expR   = W'(a % b);
      expDbz = 1'b0;
    end
  endtask

  // Wait for done (bounded), counting cycles since the accept edge and busy cycles.
  task automatic waitDone(input int startK, output int k, output int busyCnt, output bit got);
    k       = startK;
    busyCnt = 0;
    got     = 0;
    while (!got && k < 40) begin
      @(negedge clk);
      k++;
      if (bus.done) got = 1;
      else if (bus.busy) busyCnt++;
    end
  endtask

  task automatic checkResult(input string tag, input logic [W-1:0] dvd, input logic [W-1:0] dvs);
    logic [W-1:0] expQ;
    logic [W-1:0] expR;
    logic         expDbz;
    refModel(dvd, dvs, expQ, expR, expDbz);
    checkOutput({tag, "_QR"}, 32'(bus.QR), 32'(expQ));
    checkOutput({tag, "_AC"}, 32'(bus.AC), 32'(expR));
    checkOutput({tag, "_dbz"}, 32'(bus.dbz), 32'(expDbz));
  endtask

  // One full operation with a single-cycle start pulse, checking latency, busy and results.
  task automatic applyStimulus(input string tag, input logic [W-1:0] dvd, input logic [W-1:0] dvs);
    int k;
    int busyCnt;
    bit got;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = dvd;
    bus.divisor  = dvs;
    @(posedge clk);
    #1 bus.start = 1'b0;
    waitDone(0, k, busyCnt, got);
    checkOutput({tag, "_done_seen"}, 32'(got), 32'd1);
    checkOutput({tag, "_latency"}, 32'(k), (dvs == 0) ? 32'd1 : 32'(W + 2));
    checkOutput({tag, "_busy_cycles"}, 32'(busyCnt), (dvs == 0) ? 32'd0 : 32'(W + 1));
    checkOutput({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
    checkResult(tag, dvd, dvs);
    @(negedge clk);
    checkOutput({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    checkResult({tag, "_hold"}, dvd, dvs);
  endtask

  initial begin
    int k;
    int busyCnt;
    int doneCnt;
    bit got;
    logic [W-1:0] rd;
    logic [W-1:0] rv;
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    bus.start    = 1'b1;
    bus.dividend = 8'd100;
    bus.divisor  = 8'd15;

    // Reset held together with start: nothing may be accepted.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_done", 32'(bus.done), 32'd0);
    checkOutput("rst_dbz", 32'(bus.dbz), 32'd0);
    checkOutput("rst_QR", 32'(bus.QR), 32'd0);
    checkOutput("rst_AC", 32'(bus.AC), 32'd0);
    bus.start = 1'b0;
    rst       = 1'b0;

    applyStimulus("div100_15", 8'd100, 8'd15);

    // Back-to-back with start held high: second accept in the IDLE cycle after done.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 8'd32;
    bus.divisor  = 8'd16;
    @(posedge clk);
    waitDone(0, k, busyCnt, got);
    checkOutput("b2b_first_latency", 32'(k), 32'(W + 2));
    checkResult("b2b_first", 8'd32, 8'd16);
    bus.dividend = 8'd255;
    bus.divisor  = 8'd1;
    @(negedge clk);
    checkOutput("b2b_idle_gap", 32'(bus.busy), 32'd0);
    @(negedge clk);
    checkOutput("b2b_second_accept", 32'(bus.busy), 32'd1);
    bus.start = 1'b0;
    waitDone(1, k, busyCnt, got);
    checkOutput("b2b_second_latency", 32'(k), 32'(W + 2));
    checkResult("b2b_second", 8'd255, 8'd1);
    @(negedge clk);

    applyStimulus("dbz77", 8'd77, 8'd0);
    applyStimulus("after_dbz", 8'd200, 8'd7);

    // Reset in the middle of the iterations aborts with no done pulse.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 8'd100;
    bus.divisor  = 8'd15;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abort_busy", 32'(bus.busy), 32'd0);
    checkOutput("abort_done", 32'(bus.done), 32'd0);
    checkOutput("abort_dbz", 32'(bus.dbz), 32'd0);
    checkOutput("abort_QR", 32'(bus.QR), 32'd0);
    checkOutput("abort_AC", 32'(bus.AC), 32'd0);
    @(negedge clk);
    rst     = 1'b0;
    doneCnt = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.done) doneCnt++;
    end
    checkOutput("abort_no_done", 32'(doneCnt), 32'd0);
    applyStimulus("after_abort", 8'd100, 8'd15);

    // A start pulse while busy is ignored and not queued.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 8'd100;
    bus.divisor  = 8'd15;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 8'd50;
    bus.divisor  = 8'd5;
    @(negedge clk);
    bus.start = 1'b0;
    doneCnt   = 0;
    got       = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.done) begin
        doneCnt++;
        if (!got) checkResult("busy_start", 8'd100, 8'd15);
        got = 1;
      end
    end
    checkOutput("busy_start_done_count", 32'(doneCnt), 32'd1);

`ifdef DIVIDER_SIGNED_EN
    applyStimulus("neg100_15", 8'h9C, 8'd15);
    applyStimulus("100_neg15", 8'd100, 8'hF1);
`endif

    for (int i = 0; i < 30; i++) begin
      rd = W'($urandom);
      rv = ($urandom_range(0, 7) == 0) ? 8'd0 : W'($urandom);
      applyStimulus($sformatf("rand%0d", i), rd, rv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/booth_divider.md
# booth_divider

Sequential non-restoring divider, the inverse companion to the Booth multiplier: it takes a dividend and divisor and returns quotient in QR and remainder in AC, using the same register naming as the multiplier datapath. It performs one shift/add-or-subtract step per clock under a start/done handshake. It sits beside the multiplier in the arithmetic unit, so a controller can issue either operation through the same style of interface.

## Interface
- DIVIDEND_WIDTH, default 8: dividend and quotient width (W).
- DIVISOR_WIDTH, default 8: divisor and remainder width; must equal DIVIDEND_WIDTH.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- dividend  input  W  numerator; captured on the accepted start edge.
- divisor  input  W  denominator; captured on the accepted start edge.
- busy  output  1  high from the cycle after accept until done.
- done  output  1  one-cycle pulse; QR/AC valid.
- dbz  output  1  divide-by-zero flag; valid with done, held until the next accept.
- QR  output  W  quotient.
- AC  output  W  remainder.

## Operation
- States: IDLE, ITER, FIX, DONE.
- IDLE: if start=1, capture operands. Internal registers:
  - A (W+1 bits, signed) = 0.
  - Q = dividend.
  - M = divisor.
  - count = W.
  - Next state is ITER.
  - If divisor==0, go directly to DONE instead, with QR={W{1}}, AC=dividend, dbz=1.
- ITER, each cycle:
  - Shift {A,Q} left by one.
  - If A was non-negative before the shift, A=A−M; otherwise A=A+M.
  - Q[0] = ~A[W] (the new sign bit).
  - count decrements; exit to FIX when count reaches 1.
- FIX: if A is negative, A=A+M. Load QR=Q and AC=A[W−1:0]. Next state is DONE.
- DONE: done=1 for exactly one cycle, then IDLE. QR, AC and dbz hold until the next accept.
- start is ignored while busy; it is not queued.
- Arithmetic is unsigned by default. A is one bit wider than W so remainder magnitudes never overflow.

## Timing
- Reset values: busy=0, done=0, dbz=0, QR=0, AC=0, state=IDLE, count=0.
- Latency, start accepted at edge 0:
  - Iterations occur at edges 1..W.
  - FIX occurs at edge W+1.
  - done is high in the cycle following edge W+1, i.e. W+2 cycles after the start cycle (10 for W=8).
- Divide-by-zero: done is high in the cycle immediately after the accept edge.
- busy is high in all ITER and FIX cycles. It falls in the same cycle done rises.
- start held high continuously: a new operation is accepted in the IDLE cycle after DONE, so back-to-back throughput is one result per W+3 cycles.
- rst asserted mid-operation: on the next edge, return to IDLE and force all outputs to their reset values. No done pulse is issued for the aborted operation.
- rst and start both high: rst wins; nothing is accepted.

## Configuration
- DIVIDER_SIGNED_EN defined: operands are two's complement.
  - Magnitudes are taken at accept and the unsigned algorithm runs unchanged.
  - FIX negates the quotient when the operand signs differ and negates the remainder when the dividend is negative (truncation toward zero).
  - Latency is unchanged.
  - Divide-by-zero still returns QR={W{1}}, AC=dividend, dbz=1.
- Undefined: unsigned only. No sign logic is synthesized.

## Structure
- Shared arithmetic package holds:
  - the state enum (IDLE, ITER, FIX, DONE);
  - the default width constant 8, shared with the multiplier;
  - the divide-by-zero quotient constant.
- One sub-module, divider_step: combinational shift plus add/subtract for a single iteration, producing the next A and the next Q bit. The top level keeps the FSM, counter and registers.

## Test plan
- Unsigned, W=8, dividend=100, divisor=15, start pulse → done exactly 10 cycles after the start cycle, QR=6, AC=10, dbz=0, busy high in the 9 cycles before done.
- dividend=32, divisor=16 → QR=2, AC=0. Then dividend=255, divisor=1 → QR=255, AC=0. Issue back-to-back with start held high: second accept in the IDLE cycle after done.
- dividend=77, divisor=0 → done in the next cycle, dbz=1, QR=8'hFF, AC=77. The next normal operation clears dbz.
- Assert rst at iteration 4 of 100/15 → all outputs 0, no done pulse. A fresh 100/15 then completes correctly.
- With DIVIDER_SIGNED_EN: −100/15 → QR=8'hFA (−6), AC=8'hF6 (−10). 100/−15 → QR=−6, AC=10.
- Pulse start while busy → ignored; the original result is unchanged and only one done pulse occurs.
